rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//   Owns the single register-file write port (addr_3/WE3/WD3). Buffers write-back requests from the ALU and
//   the load/store unit, arbitrates round-robin, and drives one registered write per cycle into RF.
//   Keeps a per-register pending scoreboard (busy_o) for the issue stage's RAW/WAW stalls.
// PARAMETERS
//   XLEN        32  data width of write-back values
//   REG_AW      5   register address width (NREG = 2**REG_AW)
//   FIFO_DEPTH  2   entries per requester FIFO; power of two, >= 2
// PORTS
//   clk_i        in   1          clock, all state on rising edge
//   reset_i      in   1          asynchronous, active-high reset
//   alu_valid_i  in   1          ALU write-back request valid
//   alu_ready_o  out  1          ALU FIFO not full
//   alu_rd_i     in   REG_AW     ALU destination register
//   alu_wd_i     in   XLEN       ALU result
//   lsu_valid_i  in   1          LSU (load data) write-back request valid
//   lsu_ready_o  out  1          LSU FIFO not full
//   lsu_rd_i     in   REG_AW     LSU destination register
//   lsu_wd_i     in   XLEN       load data
//   pend_set_i   in   1          issue stage marks pend_rd_i as pending
//   pend_rd_i    in   REG_AW     register being marked pending
//   rf_we_o      out  1          to RF WE3_i
//   rf_waddr_o   out  REG_AW     to RF addr_3_i
//   rf_wdata_o   out  XLEN       to RF WD3_i
//   busy_o       out  2**REG_AW  pending-write bit per register; bit 0 constant 0
//   err_o        out  1          sticky: pend_set_i on an already-busy register
// BEHAVIOUR
//   Reset (async, reset_i=1): both FIFOs empty, rr pointer = ALU, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0,
//     busy_o=0, err_o=0; ready outputs follow FIFO state (both 1 while reset held). Reset mid-operation
//     discards all buffered requests; no partial write is issued.
//   Accept: push on rising edge when valid_i && ready_o. ready_o = !full, independent of valid_i (no
//     combinational valid->ready path). Same-edge push+pop on a full FIFO is not allowed: ready_o low when full.
//   Arbitration per cycle on FIFO heads: one non-empty -> grant it; both -> grant the one NOT granted last
//     (rr pointer); after reset ALU wins the first tie. rr pointer updates only on a grant.
//   Grant pops the head at the next edge and loads rf_we_o/rf_waddr_o/rf_wdata_o; RF writes on the
//     following edge. Latency: accepted at edge k -> rf_we_o high in cycle after edge k+1 (best case).
//   rf_we_o is high exactly one cycle per granted entry; deasserts with no grant. Throughput 1 write/cycle total.
//   rd == 0: entry granted and popped normally (slot consumed), but rf_we_o=0 that cycle.
//   Scoreboard: busy[r] set at edge when pend_set_i && pend_rd_i==r && r!=0; cleared at edge when
//     rf_we_o && rf_waddr_o==r. Same-edge set and clear of r -> set wins (stays 1).
//   err_o set when pend_set_i && busy[pend_rd_i] && pend_rd_i!=0 and the same-edge clear does not hit it;
//     sticky until reset. Bit set regardless.
//   Write to a register not marked busy is legal (no error); just written.
//   Per-requester order preserved; no request dropped or duplicated.
// STRUCTURE
//   Package rf_wb_pkg: XLEN, REG_AW, NREG constants; REQ_ALU=1'b0, REQ_LSU=1'b1 grant encodings;
//     typedef wb_req_t {rd, wd}.
//   Sub-module rf_wb_fifo (#FIFO_DEPTH, payload wb_req_t): push/pop/full/empty, count-based, async reset;
//     instantiated twice. Arbiter, output register and scoreboard stay in rf_wb_arbiter.
// TESTING
//   1 ALU rd=5 wd=0xDEADBEEF, pend_set rd=5 beforehand -> rf_we_o=1, waddr=5, wdata=0xDEADBEEF 2 edges after
//     accept; busy_o[5] 1 -> 0 at the RF-write edge; err_o=0.
//   2 Both valid every cycle, ALU rd=1,3,5,7 / LSU rd=2,4,6,8 -> write order 1,2,3,4,5,6,7,8; no gaps.
//   3 ALU pushes 6 back-to-back while LSU pushes 6 -> ready_o drops when FIFO holds 2; all 12 writes appear,
//     per-source order intact; rf_we_o high every cycle until drained.
//   4 ALU rd=0 wd=0x1234 then rd=9 -> slot with rf_we_o=0, then write to 9 next cycle; busy_o[0] stays 0.
//   5 pend_set rd=7 on edge where write to 7 retires -> busy_o[7]=1, err_o=0; pend_set rd=7 again -> err_o=1.
//   6 Fill both FIFOs, assert reset_i between edges -> outputs zero immediately; after release no stale write.

Source files
------------

// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_wb_pkg : shared widths, grant encodings and write-back request type
// Rev 1.0
// ----------------------------------------------------------------------------
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 2 ** REG_AW;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_wb_fifo : count-based request FIFO, head visible combinationally
// Rev 1.0
// ----------------------------------------------------------------------------
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type T          = wb_req_t
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  T              mem_q [FIFO_DEPTH];
  T              mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_wb_arbiter : ALU/LSU write-back buffering, round-robin RF write port,
//                 per-register pending scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int XLEN       = rf_wb_pkg::XLEN,
  parameter int REG_AW     = rf_wb_pkg::REG_AW,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [REG_AW-1:0]    alu_rd_i,
  input  logic [XLEN-1:0]      alu_wd_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [REG_AW-1:0]    lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_wd_i,
  input  logic                 pend_set_i,
  input  logic [REG_AW-1:0]    pend_rd_i,
  output logic                 rf_we_o,
  output logic [REG_AW-1:0]    rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic [2**REG_AW-1:0] busy_o,
  output logic                 err_o
);

  localparam int NR = 2 ** REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } req_t;

  req_t              alu_push, lsu_push, alu_head, lsu_head, head;
  logic              alu_full, alu_empty, lsu_full, lsu_empty;
  logic              alu_pop, lsu_pop;
  logic              gnt_valid, gnt_sel, retire_hit;
  logic              prio_q, prio_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NR-1:0]     busy_q, busy_d;
  logic              err_q, err_d;

  assign alu_push    = '{rd: alu_rd_i, wd: alu_wd_i};
  assign lsu_push    = '{rd: lsu_rd_i, wd: lsu_wd_i};
  assign alu_ready_o = !alu_full;
  assign lsu_ready_o = !lsu_full;

  rf_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(req_t)) u_alu_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (alu_valid_i),
    .push_data_i (alu_push),
    .pop_i       (alu_pop),
    .head_o      (alu_head),
    .full_o      (alu_full),
    .empty_o     (alu_empty)
  );

  rf_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(req_t)) u_lsu_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (lsu_valid_i),
    .push_data_i (lsu_push),
    .pop_i       (lsu_pop),
    .head_o      (lsu_head),
    .full_o      (lsu_full),
    .empty_o     (lsu_empty)
  );

  // prio_q names the requester that wins the next tie.
  always_comb begin
    gnt_valid  = !alu_empty || !lsu_empty;
    gnt_sel    = (alu_empty || (!lsu_empty && prio_q == REQ_LSU)) ? REQ_LSU : REQ_ALU;
    alu_pop    = gnt_valid && (gnt_sel == REQ_ALU);
    lsu_pop    = gnt_valid && (gnt_sel == REQ_LSU);
    head       = (gnt_sel == REQ_LSU) ? lsu_head : alu_head;
    prio_d     = gnt_valid ? ~gnt_sel : prio_q;
    rf_we_d    = gnt_valid && (head.rd != '0);
    rf_waddr_d = gnt_valid ? head.rd : rf_waddr_q;
    rf_wdata_d = gnt_valid ? head.wd : rf_wdata_q;
  end

  // Set is applied after clear so a same-edge set on a retiring register wins.
  always_comb begin
    busy_d     = busy_q;
    retire_hit = rf_we_q && (rf_waddr_q == pend_rd_i);
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (pend_set_i) begin
      busy_d[pend_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    err_d     = err_q ||
                (pend_set_i && (pend_rd_i != '0) && busy_q[pend_rd_i] && !retire_hit);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prio_q     <= REQ_ALU;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire
